// File: rtl/adc_scan_ctrl.sv
// Scan sequencer for a shared ADC: steps the analog mux over the masked channels,
// settles, captures, and keeps one result per channel. Define ADC_SCAN_AVG_EN for 4-sample averaging.
module adc_scan_ctrl #(
  parameter int BITS       = 12,
  parameter int N_CH       = 2,
  parameter int SETTLE_CYC = 4,
  parameter int PERIOD     = 1000,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      ch_mask,
  input  logic                 ovr_clr,
  input  logic [BITS-1:0]      adc_data,
  output logic [CH_W-1:0]      ch_sel,
  output logic                 busy,
  output logic                 data_valid,
  output logic [CH_W-1:0]      data_ch,
  output logic [N_CH*BITS-1:0] result,
  output logic                 scan_done,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] per_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [N_CH-1:0]  scan_mask;
  logic             tick;
  logic [CH_W:0]    first_ch;   // {found, index}
  logic [CH_W:0]    next_ch;
  logic             cap_last;
  logic [BITS-1:0]  cap_val;

  // Lowest set bit of m at or above index start; MSB flags whether one exists.
  function automatic logic [CH_W:0] find_ch(input logic [N_CH-1:0] m, input int start);
    logic [CH_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i >= start && m[i]) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

`ifdef ADC_SCAN_AVG_EN
  logic [1:0]      cap_cnt;
  logic [BITS+1:0] acc;
  logic [BITS+1:0] avg_sum;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick     = enable && (per_cnt == CNT_W'(PERIOD - 1));
    first_ch = find_ch(ch_mask, 0);
    next_ch  = find_ch(scan_mask, int'(ch_sel) + 1);
`ifdef ADC_SCAN_AVG_EN
    avg_sum  = acc + (BITS+2)'(adc_data);
    cap_last = (cap_cnt == 2'd3);
    cap_val  = avg_sum[BITS+1:2];
`else
    cap_last = 1'b1;
    cap_val  = adc_data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      settle_cnt <= '0;
      scan_mask  <= '0;
      ch_sel     <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_ch    <= '0;
      // NOTE: the result bank is reset because consumers treat 0 as "no reading yet".
      result     <= '0;
      scan_done  <= 1'b0;
      overrun    <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      cap_cnt    <= '0;
      acc        <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      scan_done  <= 1'b0;

      if (!enable)     per_cnt <= '0;
      else if (tick)   per_cnt <= '0;
      else             per_cnt <= per_cnt + 1'b1;

      // A set in the same cycle as a clear must win.
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)          overrun <= 1'b0;

      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tick && first_ch[CH_W]) begin
              scan_mask  <= ch_mask;
              ch_sel     <= first_ch[CH_W-1:0];
              settle_cnt <= '0;
              state      <= SETTLE;
              busy       <= 1'b1;
            end
          end
          SETTLE: begin
            if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
              state <= CAPTURE;
`ifdef ADC_SCAN_AVG_EN
              cap_cnt <= '0;
              acc     <= '0;
`endif
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          CAPTURE: begin
            if (cap_last) begin
              for (int k = 0; k < N_CH; k++) begin
                if (CH_W'(k) == ch_sel) result[k*BITS +: BITS] <= cap_val;
              end
              data_valid <= 1'b1;
              data_ch    <= ch_sel;
              if (next_ch[CH_W]) begin
                ch_sel     <= next_ch[CH_W-1:0];
                settle_cnt <= '0;
                state      <= SETTLE;
              end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                scan_done <= 1'b1;
              end
            end
`ifdef ADC_SCAN_AVG_EN
            else begin
              acc     <= avg_sum;
              cap_cnt <= cap_cnt + 1'b1;
            end
`endif
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: directed scans push expected captures, a monitor checks them.
module tb_adc_scan_ctrl;

  localparam int S = 4;
`ifdef ADC_SCAN_AVG_EN
  localparam int LC = 4;
`else
  localparam int LC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  ch_mask = 2'b00;
  logic        ovr_clr = 1'b0;
  logic [11:0] adc_data;
  logic [0:0]  ch_sel;
  logic        busy, data_valid, scan_done, overrun;
  logic [0:0]  data_ch;
  logic [23:0] result;

  logic        en2 = 1'b0;
  logic        clr2 = 1'b0;
  logic [11:0] adc2;
  logic [0:0]  ch_sel2, data_ch2;
  logic        busy2, data_valid2, scan_done2, overrun2;
  logic [23:0] result2;

  logic        ramp_mode = 1'b0;
  logic [11:0] ramp_val = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [0:0]  ch;
    logic [11:0] data;
    logic        done;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    adc_data = ramp_mode ? ramp_val : ((ch_sel == 1'b0) ? 12'h123 : 12'hABC);
    adc2     = (ch_sel2 == 1'b0) ? 12'h123 : 12'hABC;
  end

  adc_scan_ctrl #(.BITS(12), .N_CH(2), .SETTLE_CYC(S), .PERIOD(100)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .ovr_clr(ovr_clr),
    .adc_data(adc_data), .ch_sel(ch_sel), .busy(busy), .data_valid(data_valid),
    .data_ch(data_ch), .result(result), .scan_done(scan_done), .overrun(overrun)
  );

  adc_scan_ctrl #(.BITS(12), .N_CH(2), .SETTLE_CYC(S), .PERIOD(8)) dut_ovr (
    .clk(clk), .rst(rst), .enable(en2), .ch_mask(2'b11), .ovr_clr(clr2),
    .adc_data(adc2), .ch_sel(ch_sel2), .busy(busy2), .data_valid(data_valid2),
    .data_ch(data_ch2), .result(result2), .scan_done(scan_done2), .overrun(overrun2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    wait_cyc(c);
    @(negedge clk);
  endtask

  task automatic expect_valid(input int c, input logic [0:0] ch, input logic [11:0] d, input logic done);
    exp_t e;
    e.cyc = c; e.ch = ch; e.data = d; e.done = done;
    sb.push_back(e);
  endtask

  // Monitor: every data_valid must match the oldest expected capture.
  always @(negedge clk) begin
    if (data_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
        check("data_ch", data_ch, e.ch);
        check("result_slice", (data_ch == 1'b0) ? result[11:0] : result[23:12], e.data);
        check("scan_done", scan_done, e.done);
        if (e.done) check("busy_at_done", busy, 1'b0);
      end
    end else if (scan_done) begin
      check("done_without_valid", 1'b1, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t, v0, v1, nb;

    // Reset values
    at_neg(2);
    check("rst_busy", busy, 1'b0);
    check("rst_ch_sel", ch_sel, 1'b0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_result", result, 24'h0);
    check("rst_done", scan_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    wait_cyc(4);
    rst = 1'b0;

    // Basic scan, two periods
    wait_cyc(6);
    ch_mask = 2'b11; enable = 1'b1; e = cyc; t = e + 99;
    v0 = t + S + LC + 1; v1 = v0 + S + LC;
    expect_valid(v0, 1'b0, 12'h123, 1'b0);
    expect_valid(v1, 1'b1, 12'hABC, 1'b1);
    expect_valid(v0 + 100, 1'b0, 12'h123, 1'b0);
    expect_valid(v1 + 100, 1'b1, 12'hABC, 1'b1);
    at_neg(t);
    check("busy_before_tick", busy, 1'b0);
    at_neg(t + 1);
    check("busy_after_tick", busy, 1'b1);
    check("ch_sel_first", ch_sel, 1'b0);
    at_neg(v1 + 102);
    check("result_both", result, 24'hABC123);
    enable = 1'b0;

    // Mask 2'b10 after reset: only ch1 captured
    wait_cyc(cyc + 2);
    rst = 1'b1;
    at_neg(cyc + 1);
    check("rst_clears_result", result, 24'h0);
    wait_cyc(cyc + 1);
    rst = 1'b0;
    wait_cyc(cyc + 2);
    ch_mask = 2'b10; enable = 1'b1; e = cyc; t = e + 99;
    expect_valid(t + S + LC + 1, 1'b1, 12'hABC, 1'b1);
    at_neg(t + 1);
    check("ch_sel_mask10", ch_sel, 1'b1);
    at_neg(t + S + LC + 4);
    check("result_mask10", result, 24'hABC000);
    enable = 1'b0;

    // Mask 2'b00: ticks ignored
    wait_cyc(cyc + 2);
    ch_mask = 2'b00; enable = 1'b1; nb = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("mask0_busy_cycles", 64'(nb), 64'd0);
    check("mask0_overrun", overrun, 1'b0);
    enable = 1'b0;

    // Abort during ch0 settle
    wait_cyc(cyc + 2);
    ch_mask = 2'b11; enable = 1'b1; e = cyc; t = e + 99;
    wait_cyc(t + 2);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy_same", busy, 1'b1);
    at_neg(t + 3);
    check("abort_busy_next", busy, 1'b0);
    at_neg(t + 25);
    check("abort_result", result, 24'hABC000);

    // Reset during ch1 capture
    ch_mask = 2'b11; enable = 1'b1; e = cyc; t = e + 99;
    v0 = t + S + LC + 1; v1 = v0 + S + LC;
    expect_valid(v0, 1'b0, 12'h123, 1'b0);
    wait_cyc(v1 - 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ch_sel", ch_sel, 1'b0);
    check("midrst_result", result, 24'h0);
    check("midrst_valid", data_valid, 1'b0);
    wait_cyc(cyc + 2);
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("postrst_busy_cycles", 64'(nb), 64'd0);
    enable = 1'b0;

    // Overrun on the PERIOD=8 instance
    wait_cyc(cyc + 2);
    en2 = 1'b1; e = cyc;
    at_neg(e + 14);
    check("ovr_before", overrun2, 1'b0);
    wait_cyc(e + 15);
    clr2 = 1'b1;
    wait_cyc(e + 16);
    clr2 = 1'b0;
    @(negedge clk);
    check("ovr_set_beats_clr", overrun2, 1'b1);
    wait_cyc(e + 19);
    clr2 = 1'b1;
    @(negedge clk);
    check("ovr_held", overrun2, 1'b1);
    wait_cyc(e + 20);
    clr2 = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun2, 1'b0);
    en2 = 1'b0;

`ifdef ADC_SCAN_AVG_EN
    // Averaging: 100..103 across the four capture clocks
    wait_cyc(cyc + 2);
    ramp_mode = 1'b1; ramp_val = 12'd0;
    ch_mask = 2'b01; enable = 1'b1; e = cyc; t = e + 99;
    expect_valid(t + S + 5, 1'b0, 12'd101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(t + S + 1 + i);
      ramp_val = 12'(100 + i);
    end
    at_neg(t + S + 8);
    check("avg_result", result[11:0], 12'd101);
    enable = 1'b0;
    ramp_mode = 1'b0;
`endif

    wait_cyc(cyc + 5);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Sequencer for the shared 12-bit sensor ADC. It time-multiplexes a single ADC across up to 8 analog sensors, such as the current sensor and the 180° position sensor. It drives the analog-mux select, waits a settling time, captures the ADC code and stores it in a per-channel result register. Scans repeat every PERIOD clocks. The block sits between the ADC front-end and the control loop that consumes the sensor readings.

## Interface
Parameters:
- BITS, 12, ADC code width.
- N_CH, 2, number of channels (1..8).
- SETTLE_CYC, 4, mux-settling clocks before each capture (≥1).
- PERIOD, 1000, clocks between scan starts (≥2).
- CH_W, max(1, $clog2(N_CH)), channel index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scanning enabled.
- ch_mask  in  N_CH  channels included in a scan; latched at scan start.
- ovr_clr  in  1  clears sticky overrun.
- adc_data  in  BITS  ADC output code.
- ch_sel  out  CH_W  analog-mux select.
- busy  out  1  scan in progress.
- data_valid  out  1  one-clock pulse; a result register was just updated.
- data_ch  out  CH_W  channel of the current data_valid.
- result  out  N_CH*BITS  per-channel last result; channel k occupies [k*BITS +: BITS].
- scan_done  out  1  one-clock pulse after the last channel of a scan.
- overrun  out  1  sticky; a scan start was due while busy.

## Operation
- Period counter:
  - Counts 0..PERIOD-1 and wraps while enable=1.
  - Held at 0 while enable=0.
  - A "tick" occurs when it is at PERIOD-1.
- FSM states are IDLE, SETTLE and CAPTURE.
- IDLE:
  - On a tick with ch_mask≠0, latch ch_mask into scan_mask.
  - Set ch_sel to the lowest set bit, clear the settle counter and go to SETTLE.
  - A tick with ch_mask=0 is ignored and does not set overrun.
- SETTLE: ch_sel is held; the state stays SETTLE_CYC clocks, then goes to CAPTURE.
- CAPTURE (1 clock):
  - At the closing edge, adc_data is written to result[ch_sel] and data_valid=1, data_ch=ch_sel are registered.
  - If a higher set bit exists in scan_mask, ch_sel moves to that bit and the FSM returns to SETTLE.
  - Otherwise the FSM returns to IDLE with scan_done=1.
- Channels are always scanned in ascending index order. ch_mask changes mid-scan have no effect.
- Overrun:
  - A tick while not in IDLE sets overrun. That scan start is dropped; the current scan continues.
  - ovr_clr clears overrun. If set and clear occur in the same cycle, set wins.
- enable=0 mid-scan aborts immediately:
  - The FSM goes to IDLE next clock.
  - No data_valid or scan_done is produced for the aborted channel.
  - result registers are unchanged.
- busy=1 in SETTLE and CAPTURE, 0 in IDLE.

## Timing
- All outputs are registered.
- Reset values: ch_sel=0, busy=0, data_valid=0, data_ch=0, result=all 0, scan_done=0, overrun=0, FSM=IDLE, counters=0.
- Tick at cycle T: busy=1 and ch_sel valid from T+1.
- Per-channel latency (non-averaging): SETTLE_CYC+1 clocks.
  - The capture edge is at T+1+SETTLE_CYC.
  - data_valid is high during the following cycle.
- scan_done is coincident with the data_valid of the last channel. busy=0 in that same cycle.
- Scan length with m enabled channels: m*(SETTLE_CYC+1) clocks (non-averaging).
- No overrun occurs if PERIOD > scan length.
- Asynchronous reset at any point returns all state to reset values at once. After release, the first tick occurs PERIOD clocks after enable is seen high.

## Configuration
- ADC_SCAN_AVG_EN defined:
  - CAPTURE lasts 4 consecutive clocks, and adc_data is summed into a (BITS+2)-bit accumulator.
  - The result is the sum >> 2, truncated.
  - A single data_valid is issued after the 4th sample.
  - Per-channel latency becomes SETTLE_CYC+4.
- Not defined: a single-sample capture as described above. The accumulator logic is absent.

## Test plan
- Basic scan:
  - Setup: N_CH=2, SETTLE_CYC=4, PERIOD=100, mask=2'b11; adc_data = 0x123 when ch_sel=0, 0xABC when ch_sel=1.
  - Response: data_valid for ch0 then ch1, 5 clocks apart. result = {0xABC, 0x123}. scan_done with the second valid. Repeats every 100 clocks.
- Mask handling:
  - mask=2'b10 → only ch1 is captured; result[0] stays 0.
  - mask=2'b00 → busy never asserts and overrun stays 0.
- Overrun:
  - Setup: PERIOD=8, SETTLE_CYC=4, mask=2'b11 (scan length 10).
  - Response: overrun=1 after the second tick.
  - ovr_clr pulsed on a set cycle → overrun stays 1. A later ovr_clr with no new overrun → 0.
- Abort: enable dropped during ch0 SETTLE → busy=0 next clock, no data_valid, result unchanged.
- Reset: rst asserted mid-CAPTURE → all outputs at reset values immediately; no data_valid after release until a new tick.
- Averaging (ADC_SCAN_AVG_EN): adc_data 100, 101, 102, 103 across the 4 capture clocks → result=101, one data_valid.
